bus_arbiter: RTL and testbench

- Shares the single bus master port between two requesters: port 0 = instruction fetch, port 1 = load/store unit.
- Owns the bus trans/address/write signals and sequences one NONSEQ single transfer at a time: address phase, then data phase.
- Returns read data and error status to the winning requester.
- Default policy is fixed priority to load/store, with a starvation guard for fetch.

---
 rtl/bus_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-port bus arbiter: fetch (port 0) and load/store (port 1) share one single-transfer bus master.
// Default: load/store priority with a fetch starvation guard; define ARB_ROUND_ROBIN_EN for round-robin.
module bus_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic                  write0,
  input  logic                  write1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  done0,
  output logic                  done1,
  output logic                  error0,
  output logic                  error1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  owner,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] bus_address,
  output logic                  bus_write,
  output logic [DATA_WIDTH-1:0] bus_write_data,
  output logic [1:0]            bus_trans,
  input  logic                  bus_ready,
  input  logic                  bus_response,
  input  logic [DATA_WIDTH-1:0] bus_read_data
);

  localparam logic [1:0] BUS_TRANSFER_IDLE   = 2'b00;
  localparam logic [1:0] BUS_TRANSFER_NONSEQ = 2'b10;
  localparam logic       RESP_ERROR          = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_grant;
  logic   w_winner;

`ifdef ARB_ROUND_ROBIN_EN
  // Port favoured on the next contested grant; reset favours fetch.
  logic r_ptr;

  always_comb begin
    w_winner = req1;
    if (req0 && req1) w_winner = r_ptr;
  end

  always_ff @(posedge clock) begin
    if (reset)        r_ptr <= 1'b0;
    else if (w_grant) r_ptr <= ~w_winner;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] r_starve;

  always_comb begin
    w_winner = req1;
    if (req0 && req1 && (r_starve == LIMIT)) w_winner = 1'b0;
  end

  // Counts load/store wins that made a waiting fetch lose.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve <= 4'd0;
    end else if (w_grant) begin
      if (!w_winner)                      r_starve <= 4'd0;
      else if (req0 && r_starve != LIMIT) r_starve <= r_starve + 4'd1;
    end
  end
`endif

  always_comb begin
    w_next_state = r_state;
    w_grant      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus_ready && (req0 || req1)) begin
          w_grant      = 1'b1;
          w_next_state = S_ADDR;
        end
      end
      S_ADDR:  if (bus_ready) w_next_state = S_DATA;
      S_DATA:  if (bus_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus_trans      <= BUS_TRANSFER_IDLE;
      bus_address    <= '0;
      bus_write      <= 1'b0;
      bus_write_data <= '0;
      done0          <= 1'b0;
      done1          <= 1'b0;
      error0         <= 1'b0;
      error1         <= 1'b0;
      rdata          <= '0;
      owner          <= 1'b0;
      busy           <= 1'b0;
    end else begin
      done0  <= 1'b0;
      done1  <= 1'b0;
      error0 <= 1'b0;
      error1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            bus_address <= w_winner ? addr1 : addr0;
            bus_write   <= w_winner ? write1 : write0;
            bus_trans   <= BUS_TRANSFER_NONSEQ;
            owner       <= w_winner;
            busy        <= 1'b1;
          end
        end
        S_ADDR: begin
          if (bus_ready) begin
            bus_trans      <= BUS_TRANSFER_IDLE;
            bus_write_data <= owner ? wdata1 : wdata0;
          end
        end
        S_DATA: begin
          if (bus_ready) begin
            done0  <= ~owner;
            done1  <= owner;
            error0 <= ~owner & (bus_response == RESP_ERROR);
            error1 <= owner & (bus_response == RESP_ERROR);
            if (!bus_write) rdata <= bus_read_data;
            busy   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized bench for bus_arbiter: transaction-level requester/slave model with arbitration predicted
// from the priority rules (or round-robin when ARB_ROUND_ROBIN_EN is defined).
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;

  logic clock = 1'b0;
  logic reset;
  logic req0, req1, write0, write1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic done0, done1, error0, error1, owner, busy, bus_write;
  logic [DW-1:0] rdata, bus_write_data, bus_read_data;
  logic [AW-1:0] bus_address;
  logic [1:0] bus_trans;
  logic bus_ready, bus_response;

  always #5 clock = ~clock;

  bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .write0(write0), .write1(write1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .error0(error0), .error1(error1),
    .rdata(rdata), .owner(owner), .busy(busy),
    .bus_address(bus_address), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_trans(bus_trans), .bus_ready(bus_ready), .bus_response(bus_response),
    .bus_read_data(bus_read_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Requester state and model state
  bit          m_req[2];
  logic [31:0] m_addr[2];
  logic [31:0] m_wdata[2];
  bit          m_write[2];
  bit          allow[2];
  int          req_pct;
  int          rdy_pct;
  logic [31:0] exp_rdata;
  int          grant_log[$];
`ifdef ARB_ROUND_ROBIN_EN
  int          rr_next;
`else
  int          starve;
`endif

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (r1 && !r0) return 1;
    if (r0 && !r1) return 0;
`ifdef ARB_ROUND_ROBIN_EN
    return rr_next;
`else
    return (starve == SL) ? 0 : 1;
`endif
  endfunction

  task automatic note_grant(input int w, input bit r0);
`ifdef ARB_ROUND_ROBIN_EN
    rr_next = (w == 0) ? 1 : 0;
`else
    if (w == 0) starve = 0;
    else if (r0 && starve < SL) starve++;
`endif
  endtask

  task automatic model_reset();
`ifdef ARB_ROUND_ROBIN_EN
    rr_next = 0;
`else
    starve = 0;
`endif
    exp_rdata = 32'h0;
    m_req[0] = 1'b0;
    m_req[1] = 1'b0;
  endtask

  task automatic maybe_new_req(input int p);
    if (allow[p] && !m_req[p] && pct(req_pct)) begin
      m_req[p]   = 1'b1;
      m_addr[p]  = $urandom;
      m_wdata[p] = $urandom;
      m_write[p] = 1'($urandom_range(0, 1));
    end
  endtask

  // lvl 1 disturbs the owner's addr/write, lvl 2 additionally its wdata
  task automatic drive(input int pw, input int lvl);
    req0 = m_req[0]; addr0 = m_addr[0]; write0 = m_write[0]; wdata0 = m_wdata[0];
    req1 = m_req[1]; addr1 = m_addr[1]; write1 = m_write[1]; wdata1 = m_wdata[1];
    if (pw == 0 && lvl >= 1) begin addr0 = ~m_addr[0]; write0 = ~m_write[0]; end
    if (pw == 0 && lvl >= 2) wdata0 = ~m_wdata[0];
    if (pw == 1 && lvl >= 1) begin addr1 = ~m_addr[1]; write1 = ~m_write[1]; end
    if (pw == 1 && lvl >= 2) wdata1 = ~m_wdata[1];
  endtask

  task automatic run_xfer();
    int w;
    int guard;
    bit r0, r1, rdy, rsp;
    logic [31:0] rd;
    guard = 0;
    forever begin
      maybe_new_req(0);
      maybe_new_req(1);
      rdy = pct(rdy_pct);
      drive(-1, 0);
      bus_ready = rdy;
      bus_response = 1'($urandom_range(0, 1));
      bus_read_data = $urandom;
      r0 = m_req[0];
      r1 = m_req[1];
      @(negedge clock);
      chk("no_done0", done0, 0);
      chk("no_done1", done1, 0);
      if (rdy && (r0 || r1)) break;
      chk("idle_trans", bus_trans, T_IDLE);
      chk("idle_busy", busy, 0);
      guard++;
      if (guard > 60) begin chk("grant_timeout", 0, 1); return; end
    end
    w = pick(r0, r1);
    note_grant(w, r0);
    grant_log.push_back(w);
    chk("owner", owner, w);
    chk("trans_nonseq", bus_trans, T_NONSEQ);
    chk("bus_addr", bus_address, m_addr[w]);
    chk("bus_write", bus_write, m_write[w]);
    chk("busy_addr", busy, 1);

    guard = 0;
    do begin
      rdy = pct(rdy_pct);
      drive(w, 1);
      bus_ready = rdy;
      @(negedge clock);
      if (!rdy) begin
        chk("addr_hold_trans", bus_trans, T_NONSEQ);
        chk("addr_hold_addr", bus_address, m_addr[w]);
      end
      guard++;
      if (guard > 60) begin chk("addr_timeout", 0, 1); return; end
    end while (!rdy);
    chk("data_trans", bus_trans, T_IDLE);
    chk("wdata", bus_write_data, m_wdata[w]);
    chk("busy_data", busy, 1);

    guard = 0;
    do begin
      rdy = pct(rdy_pct);
      rsp = 1'($urandom_range(0, 1));
      rd  = $urandom;
      drive(w, 2);
      bus_ready = rdy;
      bus_response = rsp;
      bus_read_data = rd;
      @(negedge clock);
      if (!rdy) begin
        chk("early_done", done0 | done1, 0);
        chk("wdata_hold", bus_write_data, m_wdata[w]);
      end
      guard++;
      if (guard > 60) begin chk("data_timeout", 0, 1); return; end
    end while (!rdy);
    if (!m_write[w]) exp_rdata = rd;
    chk("done_own", (w == 1) ? done1 : done0, 1);
    chk("done_other", (w == 1) ? done0 : done1, 0);
    chk("error_own", (w == 1) ? error1 : error0, rsp);
    chk("error_other", (w == 1) ? error0 : error1, 0);
    chk("rdata", rdata, exp_rdata);
    chk("busy_done", busy, 0);
    m_req[w] = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    drive(-1, 0);
    bus_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  int exp_order[10];

  initial begin
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
`endif
    m_addr  = '{32'h0, 32'h0};
    m_wdata = '{32'h0, 32'h0};
    m_write = '{1'b0, 1'b0};
    bus_response = 1'b0;
    bus_read_data = '0;
    reset = 1'b1;
    model_reset();
    drive(-1, 0);
    bus_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_trans", bus_trans, T_IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_done", {done0, done1, error0, error1}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_owner", owner, 0);
    chk("rst_addr", bus_address, 0);
    chk("rst_wdata", bus_write_data, 0);
    reset = 1'b0;

    // single fetch transfer, zero-wait slave
    allow = '{1'b1, 1'b0};
    req_pct = 100;
    rdy_pct = 100;
    run_xfer();

    // both requesters continuously pending
    do_reset();
    allow = '{1'b1, 1'b1};
    grant_log.delete();
    repeat (10) run_xfer();
    for (int i = 0; i < 10; i++) chk("grant_order", grant_log[i], exp_order[i]);

    // reset abandons a transfer in its data phase
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = 32'h100; m_write[0] = 1'b0; m_wdata[0] = 32'h0;
    drive(-1, 0);
    bus_ready = 1'b1;
    @(negedge clock);
    chk("mid_nonseq", bus_trans, T_NONSEQ);
    @(negedge clock);
    chk("mid_data_busy", busy, 1);
    reset = 1'b1;
    bus_read_data = 32'hDEADBEEF;
    @(negedge clock);
    chk("mid_trans", bus_trans, T_IDLE);
    chk("mid_busy", busy, 0);
    chk("mid_done", {done0, done1}, 0);
    chk("mid_rdata", rdata, 0);
    do_reset();
    allow = '{1'b1, 1'b0};
    run_xfer();

    // random traffic with wait states and error responses
    allow = '{1'b1, 1'b1};
    req_pct = 40;
    rdy_pct = 65;
    repeat (150) run_xfer();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
